// File: rtl/imem_loader_if.sv
// Byte-serial program load channel between a program source and imem_loader.
// The master drives bytes; the slave (the loader) signals when it can take one.
interface imem_loader_if;
   logic       load_start;
   logic       load_valid;
   logic [7:0] load_byte;
   logic       load_last;
   logic       load_ready;

   modport master (
      output load_start, load_valid, load_byte, load_last,
      input  load_ready
   );

   modport slave (
      input  load_start, load_valid, load_byte, load_last,
      output load_ready
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with a byte-serial loader: packs bytes little-endian into words,
// holds the CPU while loading and serves instr combinationally from pc once done.
//
// state   | meaning
// IDLE    | no program loaded, CPU held
// LOAD    | accepting bytes, one per cycle
// DONE    | program valid, CPU released, instr served from memory
// ERROR   | framing or overflow error, CPU held
module imem_loader #(
   parameter int          DEPTH    = 256,
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic              clock,
   input  logic              reset,
   imem_loader_if.slave      ld,
   input  logic [ADDR_W-1:0] pc,
   output logic [31:0]       instr,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   word_count
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] WC_ONE  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DONE  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   word_count_q, word_count_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [23:0]       word_buf_q, word_buf_d;
   logic              mem_we;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         word_count_q <= '0;
         byte_idx_q   <= '0;
         word_buf_q   <= '0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
         byte_idx_q   <= byte_idx_d;
         word_buf_q   <= word_buf_d;
      end
   end

   // Array is deliberately not reset; word_count gates what is readable.
   always_ff @(posedge clock) begin
      if (mem_we && !reset) begin
         mem_q[word_count_q[IDX_W-1:0]] <= mem_wdata;
      end
   end

   always_comb begin
      state_d      = state_q;
      word_count_d = word_count_q;
      byte_idx_d   = byte_idx_q;
      word_buf_d   = word_buf_q;
      mem_we       = 1'b0;
      mem_wdata    = {ld.load_byte, word_buf_q};

      case (state_q)
         S_LOAD: begin
            if (ld.load_valid) begin
               if (word_count_q == DEPTH_W) begin
                  state_d = S_ERROR;
               end else if (byte_idx_q == 2'd3) begin
                  mem_we       = 1'b1;
                  word_count_d = word_count_q + WC_ONE;
                  byte_idx_d   = 2'd0;
                  if (ld.load_last) begin
                     state_d = S_DONE;
                  end
               end else begin
                  case (byte_idx_q)
                     2'd0:    word_buf_d[7:0]   = ld.load_byte;
                     2'd1:    word_buf_d[15:8]  = ld.load_byte;
                     default: word_buf_d[23:16] = ld.load_byte;
                  endcase
                  byte_idx_d = byte_idx_q + 2'd1;
                  // A last byte mid-word is a framing error; the partial word is dropped.
                  if (ld.load_last) begin
                     state_d = S_ERROR;
                  end
               end
            end
         end
         default: begin
            if (ld.load_start) begin
               state_d      = S_LOAD;
               word_count_d = '0;
               byte_idx_d   = 2'd0;
            end
         end
      endcase
   end

   always_comb begin
      instr = NOP_WORD;
      if (state_q == S_DONE && ({1'b0, pc} < word_count_q)) begin
         instr = mem_q[pc[IDX_W-1:0]];
      end
   end

   assign ld.load_ready = (state_q == S_LOAD);
   assign load_done     = (state_q == S_DONE);
   assign load_err      = (state_q == S_ERROR);
   assign cpu_hold      = (state_q != S_DONE);
   assign word_count    = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed load streams on a full-size and a 4-word instance,
// expected snapshots queued by the driver and compared by a negedge monitor.
module tb_imem_loader;

   logic        clock;
   logic        reset;
   logic [7:0]  pc, pc4;
   logic [31:0] instr, instr4;
   logic        cpu_hold, cpu_hold4;
   logic        load_done, load_done4;
   logic        load_err, load_err4;
   logic [8:0]  word_count, word_count4;
   logic        sample_req;

   int checks = 0;
   int errors = 0;

   imem_loader_if li ();
   imem_loader_if li4 ();

   imem_loader #(.DEPTH(256), .ADDR_W(8), .NOP_WORD(32'h0000_0000)) dut (
      .clock      (clock),
      .reset      (reset),
      .ld         (li),
      .pc         (pc),
      .instr      (instr),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err),
      .word_count (word_count)
   );

   imem_loader #(.DEPTH(4), .ADDR_W(8), .NOP_WORD(32'h0000_0000)) dut4 (
      .clock      (clock),
      .reset      (reset),
      .ld         (li4),
      .pc         (pc4),
      .instr      (instr4),
      .cpu_hold   (cpu_hold4),
      .load_done  (load_done4),
      .load_err   (load_err4),
      .word_count (word_count4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic        sel4;
      logic [31:0] instr;
      logic        done;
      logic        err;
      logic        hold;
      logic        ready;
      logic [8:0]  wc;
   } snap_t;

   snap_t exp_q [$];
   string name_q [$];

   always @(negedge clock) begin
      if (sample_req) begin
         snap_t e, a;
         string n;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL monitor: sample with no expected entry, got none required one");
         end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a.sel4 = e.sel4;
            if (e.sel4) begin
               a.instr = instr4; a.done = load_done4; a.err = load_err4;
               a.hold = cpu_hold4; a.ready = li4.load_ready; a.wc = word_count4;
            end else begin
               a.instr = instr; a.done = load_done; a.err = load_err;
               a.hold = cpu_hold; a.ready = li.load_ready; a.wc = word_count;
            end
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL %s: got instr=%h done=%b err=%b hold=%b ready=%b wc=%0d, required instr=%h done=%b err=%b hold=%b ready=%b wc=%0d",
                        n, a.instr, a.done, a.err, a.hold, a.ready, a.wc,
                        e.instr, e.done, e.err, e.hold, e.ready, e.wc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input bit sel4, input logic [7:0] p,
                        input logic [31:0] ei, input logic ed, input logic ee,
                        input logic eh, input logic er, input logic [8:0] ew);
      snap_t e;
      if (sel4) pc4 = p; else pc = p;
      e.sel4 = sel4; e.instr = ei; e.done = ed; e.err = ee;
      e.hold = eh; e.ready = er; e.wc = ew;
      exp_q.push_back(e);
      name_q.push_back(name);
      sample_req = 1'b1;
      @(negedge clock);
      #1;
      sample_req = 1'b0;
   endtask

   task automatic start(input bit sel4);
      if (sel4) li4.load_start = 1'b1; else li.load_start = 1'b1;
      tick();
      li4.load_start = 1'b0;
      li.load_start  = 1'b0;
   endtask

   task automatic send_byte(input bit sel4, input logic [7:0] b, input bit last);
      if (sel4) begin
         li4.load_valid = 1'b1; li4.load_byte = b; li4.load_last = last;
      end else begin
         li.load_valid = 1'b1; li.load_byte = b; li.load_last = last;
      end
      tick();
      li.load_valid  = 1'b0; li.load_last  = 1'b0;
      li4.load_valid = 1'b0; li4.load_last = 1'b0;
   endtask

   initial begin
      logic [7:0] prog [8];
      reset = 1'b1;
      sample_req = 1'b0;
      pc = '0; pc4 = '0;
      li.load_start  = 1'b0; li.load_valid  = 1'b0; li.load_byte  = '0; li.load_last  = 1'b0;
      li4.load_start = 1'b0; li4.load_valid = 1'b0; li4.load_byte = '0; li4.load_last = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      //            name             sel pc  instr         done err hold rdy wc
      check("reset",               0, 0, 32'h0,        0,   0,  1,   0,  0);
      check("reset_d4",            1, 0, 32'h0,        0,   0,  1,   0,  0);

      // Basic two-word program.
      start(0);
      check("ready_after_start",   0, 0, 32'h0,        0,   0,  1,   1,  0);
      prog = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int i = 0; i < 8; i++) send_byte(0, prog[i], i == 7);
      check("basic_pc0",           0, 0, 32'h12345678, 1,   0,  0,   0,  2);
      check("basic_pc1",           0, 1, 32'hDEADBEEF, 1,   0,  0,   0,  2);
      check("basic_pc2_nop",       0, 2, 32'h0,        1,   0,  0,   0,  2);

      // Framing error: last on byte 6, then recover with a one-word load.
      start(0);
      for (int i = 0; i < 6; i++) send_byte(0, 8'(8'h11 * (i + 1)), i == 5);
      check("frame_err_pc0",       0, 0, 32'h0,        0,   1,  1,   0,  1);
      check("frame_err_pc1",       0, 1, 32'h0,        0,   1,  1,   0,  1);
      start(0);
      send_byte(0, 8'h01, 0); send_byte(0, 8'h02, 0);
      send_byte(0, 8'h03, 0); send_byte(0, 8'h04, 1);
      check("recover_pc0",         0, 0, 32'h04030201, 1,   0,  0,   0,  1);
      check("recover_pc1_nop",     0, 1, 32'h0,        1,   0,  0,   0,  1);

      // Gapped stream: idle cycles carry junk and a stray last without valid.
      start(0);
      for (int i = 0; i < 8; i++) begin
         send_byte(0, 8'(8'hA0 + i), i == 7);
         if (i < 7) begin
            li.load_byte = 8'hFF; li.load_last = 1'b1;
            tick();
            li.load_last = 1'b0;
         end
      end
      check("gapped_pc0",          0, 0, 32'hA3A2A1A0, 1,   0,  0,   0,  2);
      check("gapped_pc1",          0, 1, 32'hA7A6A5A4, 1,   0,  0,   0,  2);

      // Reload from DONE with a valid byte on the start cycle: that byte is not taken.
      li.load_valid = 1'b1; li.load_byte = 8'h5A; li.load_start = 1'b1;
      tick();
      li.load_valid = 1'b0; li.load_start = 1'b0;
      check("reload_hold",         0, 0, 32'h0,        0,   0,  1,   1,  0);
      send_byte(0, 8'h10, 0); send_byte(0, 8'h20, 0);
      send_byte(0, 8'h30, 0); send_byte(0, 8'h40, 1);
      check("reload_pc0",          0, 0, 32'h40302010, 1,   0,  0,   0,  1);

      // Reset mid-word, then confirm the byte index restarted.
      start(0);
      for (int i = 0; i < 10; i++) send_byte(0, 8'(i), 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_reset",           0, 0, 32'h0,        0,   0,  1,   0,  0);
      li.load_valid = 1'b1; li.load_byte = 8'h99; li.load_last = 1'b1;
      tick();
      tick();
      li.load_valid = 1'b0; li.load_last = 1'b0;
      check("idle_valid_ignored",  0, 0, 32'h0,        0,   0,  1,   0,  0);
      start(0);
      send_byte(0, 8'hC1, 0); send_byte(0, 8'hC2, 0);
      send_byte(0, 8'hC3, 0); send_byte(0, 8'hC4, 1);
      check("after_reset_pc0",     0, 0, 32'hC4C3C2C1, 1,   0,  0,   0,  1);

      // Four-word instance: exact fill, then overflow; then a full legal load.
      start(1);
      for (int i = 0; i < 16; i++) send_byte(1, 8'(i), 0);
      check("d4_full_still_load",  1, 0, 32'h0,        0,   0,  1,   1,  4);
      send_byte(1, 8'hAA, 0);
      check("d4_overflow",         1, 0, 32'h0,        0,   1,  1,   0,  4);
      start(1);
      for (int i = 0; i < 16; i++) send_byte(1, 8'(8'h20 + i), i == 15);
      check("d4_pc0",              1, 0, 32'h23222120, 1,   0,  0,   0,  4);
      check("d4_pc3",              1, 3, 32'h2F2E2D2C, 1,   0,  0,   0,  4);
      check("d4_pc4_nop",          1, 4, 32'h0,        1,   0,  0,   0,  4);

      tick();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
